// File: rtl/rca_seq_pkg.sv
// -----------------------------------------------------------------------------
// rca_seq_pkg
// Shared definitions for the sequential ripple-carry adder controller:
//   SLICE_W  - width of the shared ripple-carry slice (bits per iteration)
//   state_t  - controller state encoding (IDLE -> RUN -> DONE -> IDLE)
// -----------------------------------------------------------------------------
package rca_seq_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : rca_seq_pkg

// File: rtl/add4_slice.sv
// -----------------------------------------------------------------------------
// add4_slice
// Combinational 4-bit ripple-carry adder slice.
// Ports:
//   a, b  in  4  slice operands
//   cin   in  1  carry into bit 0
//   sum   out 4  slice sum
//   cout  out 1  carry out of bit 3
//   c3    out 1  carry into bit 3 (for signed overflow at the MSB slice)
// -----------------------------------------------------------------------------
module add4_slice
   import rca_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout,
   output logic               c3
);

   logic [SLICE_W:0] c;

   // NOTE: every signal written in always_comb gets a value on every path
   // (here via the loop and the explicit c[0]); otherwise a latch is inferred.
   always_comb begin
      c[0] = cin;
      for (int i = 0; i < SLICE_W; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[SLICE_W];
   assign c3   = c[SLICE_W - 1];

endmodule : add4_slice

// File: rtl/rca_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rca_seq_ctrl
// Multi-cycle WIDTH-bit adder. Operands are accepted over a valid/ready
// handshake, then one shared 4-bit ripple-carry slice is stepped LSB-first,
// one slice per cycle, with a carry register linking the slices. The result is
// offered over a valid/ready handshake and held until taken.
//
// Optional feature: define RCA_SEQ_SUB_EN to add the in_sub port (subtract:
// B inverted per slice, initial carry forced to 1, in_cin ignored).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     operand handshake (in_ready == state IDLE)
//   in_a, in_b, in_cin    operands and carry-in
//   in_sub                subtract select (RCA_SEQ_SUB_EN only)
//   out_valid/out_ready   result handshake
//   out_sum, out_cout     result and carry out of the MSB
//   out_ovf               signed overflow (carry into MSB ^ carry out of MSB)
//   busy                  state != IDLE
// -----------------------------------------------------------------------------
module rca_seq_ctrl
   import rca_seq_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
`ifdef RCA_SEQ_SUB_EN
   input  logic             in_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

   generate
      if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
         $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
`ifdef RCA_SEQ_SUB_EN
   logic               sub_q;
`endif

   logic [SLICE_W-1:0] a_sl;
   logic [SLICE_W-1:0] b_sl;
   logic [SLICE_W-1:0] sl_sum;
   logic               sl_cout;
   logic               sl_c3;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // Select the operand nibbles for the slice currently being processed.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int k = 0; k < NSLICE; k++) begin
         if (idx == IDX_W'(k)) begin
            a_sl = a_q[k*SLICE_W +: SLICE_W];
            b_sl = b_q[k*SLICE_W +: SLICE_W];
         end
      end
`ifdef RCA_SEQ_SUB_EN
      if (sub_q) b_sl = ~b_sl;
`endif
   end

   add4_slice u_slice (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry),
      .sum  (sl_sum),
      .cout (sl_cout),
      .c3   (sl_c3)
   );

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         // NOTE: the operand registers are plain flops, not a memory, so they
         // are reset too; this keeps the slice inputs free of X after reset.
         a_q       <= '0;
         b_q       <= '0;
`ifdef RCA_SEQ_SUB_EN
         sub_q     <= 1'b0;
`endif
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= in_a;
                  b_q   <= in_b;
                  idx   <= '0;
`ifdef RCA_SEQ_SUB_EN
                  sub_q <= in_sub;
                  carry <= in_sub ? 1'b1 : in_cin;
`else
                  carry <= in_cin;
`endif
                  state <= RUN;
               end
            end

            RUN: begin
               for (int k = 0; k < NSLICE; k++) begin
                  if (idx == IDX_W'(k)) out_sum[k*SLICE_W +: SLICE_W] <= sl_sum;
               end
               carry <= sl_cout;
               if (idx == IDX_LAST) begin
                  out_cout  <= sl_cout;
                  out_ovf   <= sl_c3 ^ sl_cout;
                  out_valid <= 1'b1;
                  idx       <= '0;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule : rca_seq_ctrl

// File: tb/tb_rca_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rca_seq_ctrl
// Scoreboard bench for rca_seq_ctrl (WIDTH=16). The driver pushes the expected
// result of every accepted operation into a queue; a negedge monitor pops and
// compares whenever a result is handed over (out_valid & out_ready), and checks
// the accept-to-valid latency. Expected values come from spec constants for the
// directed cases and from a whole-word arithmetic model for random traffic.
// -----------------------------------------------------------------------------
module tb_rca_seq_ctrl;

   localparam int W   = 16;
   localparam int NS  = W / 4;
   localparam int PER = 10;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
   logic         busy;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   time  t_acc  = 0;
   bit   rand_rdy = 0;
   bit   prev_v   = 0;

   rca_seq_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
`ifdef RCA_SEQ_SUB_EN
      .in_sub    (in_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #(PER/2) clk = ~clk;

   initial begin
      #(PER * 50000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Whole-word reference: subtraction is A + ~B + 1; signed overflow is
   // "operands of equal sign give a result of the other sign".
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      logic [W-1:0] bb;
      logic         c0;
      logic [W:0]   full;
      exp_t         e;
      bb     = sub ? ~b : b;
      c0     = sub ? 1'b1 : cin;
      full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      return e;
   endfunction

   // Monitor: latency on each rising out_valid, data on each handover.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && !prev_v)
            check("latency", 32'(($time - t_acc) / PER), 32'(NS));
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got sum 0x%0h with empty scoreboard", out_sum);
            end else begin
               e = sb_q.pop_front();
               check("sum",  out_sum,  e.sum);
               check("cout", out_cout, e.cout);
               check("ovf",  out_ovf,  e.ovf);
            end
         end
      end
      prev_v = out_valid;
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   // Called just after a rising edge. Holds in_valid until accepted.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input exp_t e);
      bit got = 0;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_sub   = sub;
      in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      if (got) begin
         sb_q.push_back(e);
         @(posedge clk);
         t_acc = $time;
         #1;
      end else begin
         check("accept_timeout", 32'(got), 32'd1);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 1000; n++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      exp_t e;
      logic [W-1:0] ra, rb;
      logic         rc, rs;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_sum",   out_sum,   '0);
      check("rst_out_cout",  out_cout,  1'b0);
      check("rst_out_ovf",   out_ovf,   1'b0);
      check("rst_in_ready",  in_ready,  1'b1);
      check("rst_busy",      busy,      1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed additions
      out_ready = 1'b1;
      send(16'h1234, 16'h4321, 1'b0, 1'b0, '{sum: 16'h5555, cout: 1'b0, ovf: 1'b0});
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
      send(16'h7FFF, 16'h0000, 1'b1, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
      drain();

      // Back-pressure in DONE, with an in_valid pulse that must be ignored
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      e = model(16'hABCD, 16'h1111, 1'b0, 1'b0);
      send(16'hABCD, 16'h1111, 1'b0, 1'b0, e);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check("hold_valid",    out_valid, 1'b1);
         check("hold_sum",      out_sum,   e.sum);
         check("hold_cout",     out_cout,  e.cout);
         check("hold_ovf",      out_ovf,   e.ovf);
         check("hold_in_ready", in_ready,  1'b0);
         if (n == 3) begin
            in_a     = 16'h0001;
            in_b     = 16'h0001;
            in_valid = 1'b1;
         end
         if (n == 5) in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("release_in_ready", in_ready,  1'b1);
      check("release_busy",     busy,      1'b0);
      check("release_valid",    out_valid, 1'b0);
      repeat (8) @(negedge clk);
      check("ignored_pulse_no_result", out_valid, 1'b0);
      check("ignored_pulse_queue",     32'(sb_q.size()), 32'd0);

      // Reset in the middle of RUN
      @(posedge clk);
      #1;
      send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #3;
      check("pre_abort_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_out_sum",   out_sum,   '0);
      check("abort_out_cout",  out_cout,  1'b0);
      check("abort_out_ovf",   out_ovf,   1'b0);
      check("abort_busy",      busy,      1'b0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(16'h00F0, 16'h0010, 1'b0, 1'b0, '{sum: 16'h0100, cout: 1'b0, ovf: 1'b0});
      drain();

`ifdef RCA_SEQ_SUB_EN
      // Subtraction
      @(posedge clk);
      #1;
      send(16'h0005, 16'h0007, 1'b0, 1'b1, '{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0});
      send(16'h8000, 16'h0001, 1'b0, 1'b1, '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1});
      drain();
`endif

      // Random traffic with random consumer back-pressure
      rand_rdy = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(0, 1));
`ifdef RCA_SEQ_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         if (i % 8 == 0) ra = {1'b0, {(W-1){1'b1}}};
         send(ra, rb, rc, rs, model(ra, rb, rc, rs));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      drain();
      rand_rdy = 0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rca_seq_ctrl
